// File: rtl/vga_frame_monitor.sv
// VGA sink checker: rebuilds pixel coordinates, checks line/frame geometry, signs each frame, reports lock.
// Define VGA_MON_CRC_EN to replace the additive frame signature with a CRC-32 over {r,g,b}.
module vga_frame_monitor #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter bit          SYNC_POL    = 1'b0,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_hsync,
  input  logic        in_vsync,
  input  logic        in_de,
  input  logic [9:0]  in_r,
  input  logic [9:0]  in_g,
  input  logic [9:0]  in_b,
  output logic [9:0]  px_x,
  output logic [9:0]  px_y,
  output logic        px_valid,
  output logic        frame_done,
  output logic [31:0] frame_sum,
  output logic [18:0] lit_count,
  output logic        locked,
  output logic        err_hline,
  output logic        err_vframe
);

  localparam int unsigned CW = 10;
  localparam int unsigned GW = 4;
  localparam int unsigned LW = 19;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [LW-1:0] LIT_MAX = '1;

`ifdef VGA_MON_CRC_EN
  localparam logic [31:0] SIG_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;

  // MSB-first CRC-32 step over one 30-bit pixel word
  function automatic logic [31:0] crc30(input logic [31:0] c, input logic [29:0] d);
    logic [31:0] n;
    n = c;
    for (int i = 29; i >= 0; i--) begin
      n = {n[30:0], 1'b0} ^ ((n[31] ^ d[i]) ? CRC_POLY : 32'd0);
    end
    return n;
  endfunction
`else
  localparam logic [31:0] SIG_INIT = 32'd0;
`endif

  typedef enum logic [1:0] {SEEK, TRACK, LOCKED} state_t;

  state_t state_q, state_d;
  logic [GW-1:0] good_q, good_d;

  // horizontal sync carries no information this checker needs
  logic hsync_unused;
  assign hsync_unused = in_hsync;

  logic          de1, de1_d, vact1, vact_d;
  logic [CW-1:0] r1, g1, b1;
  logic [CW-1:0] x_q, y_q;
  logic [31:0]   sig_q;
  logic [LW-1:0] lit_q;
  logic          bad_q;

  logic          frame_edge_c, line_end_c, hline_err_c, vframe_err_c;
  logic [CW-1:0] x_inc_c, y_line_c;
  logic [31:0]   sig_next_c;
  logic [LW-1:0] lit_next_c;

  // edge detection, counters and accumulator next values
  always_comb begin
    frame_edge_c = vact1 & ~vact_d;
    line_end_c   = de1_d & ~de1;
    x_inc_c      = (x_q == CNT_MAX) ? x_q : x_q + CW'(1);
    y_line_c     = y_q;
    if (line_end_c && (y_q != CNT_MAX)) y_line_c = y_q + CW'(1);
    hline_err_c  = line_end_c && (state_q != SEEK) && (x_q != CW'(H_ACTIVE));
    vframe_err_c = frame_edge_c && (state_q != SEEK) && (y_line_c != CW'(V_ACTIVE));
    sig_next_c   = sig_q;
    lit_next_c   = lit_q;
    if (de1) begin
`ifdef VGA_MON_CRC_EN
      sig_next_c = crc30(sig_q, {r1, g1, b1});
`else
      sig_next_c = sig_q + 32'(r1) + 32'(g1) + 32'(b1);
`endif
      if ((r1 != '0) && (g1 != '0) && (b1 != '0) && (lit_q != LIT_MAX)) lit_next_c = lit_q + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEEK;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
    end
  end

  // lock tracking; a frame is bad if any line error hit it or its line count is off
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    unique case (state_q)
      SEEK: begin
        if (frame_edge_c) begin
          state_d = TRACK;
          good_d  = '0;
        end
      end
      TRACK: begin
        if (hline_err_c || vframe_err_c) begin
          good_d = '0;
        end else if (frame_edge_c) begin
          if (bad_q) begin
            good_d = '0;
          end else if (GW'(good_q + GW'(1)) >= GW'(LOCK_FRAMES)) begin
            state_d = LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_q + GW'(1);
          end
        end
      end
      LOCKED: begin
        if (hline_err_c || vframe_err_c) begin
          state_d = TRACK;
          good_d  = '0;
        end
      end
      default: state_d = SEEK;
    endcase
  end

  // input stage, counters, accumulators and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      de1 <= 1'b0; de1_d <= 1'b0; vact1 <= 1'b0; vact_d <= 1'b0;
      r1 <= '0; g1 <= '0; b1 <= '0;
      x_q <= '0; y_q <= '0; sig_q <= '0; lit_q <= '0; bad_q <= 1'b0;
      px_x <= '0; px_y <= '0; px_valid <= 1'b0; frame_done <= 1'b0;
      frame_sum <= '0; lit_count <= '0; locked <= 1'b0;
      err_hline <= 1'b0; err_vframe <= 1'b0;
    end else begin
      de1    <= in_de;
      de1_d  <= de1;
      vact1  <= (in_vsync == SYNC_POL);
      vact_d <= vact1;
      r1 <= in_r; g1 <= in_g; b1 <= in_b;

      if (de1) x_q <= x_inc_c;
      else if (line_end_c) x_q <= '0;
      y_q <= frame_edge_c ? '0 : y_line_c;

      if (frame_edge_c) begin
        sig_q <= SIG_INIT;
        lit_q <= '0;
        bad_q <= 1'b0;
      end else begin
        sig_q <= sig_next_c;
        lit_q <= lit_next_c;
        if (hline_err_c) bad_q <= 1'b1;
      end

      px_valid <= de1;
      if (de1) begin
        px_x <= x_q;
        px_y <= y_q;
      end
      frame_done <= frame_edge_c && (state_q != SEEK);
      if (frame_edge_c && (state_q != SEEK)) begin
        frame_sum <= sig_next_c;
        lit_count <= lit_next_c;
      end
      err_hline  <= hline_err_c;
      err_vframe <= vframe_err_c;
      locked     <= (state_d == LOCKED);
    end
  end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Scoreboard bench for vga_frame_monitor on a reduced 8x6 geometry; stimulus pushes expectations, a monitor pops them.
module tb_vga_frame_monitor;

  localparam int H = 8;
  localparam int V = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_hsync = 1'b1, in_vsync = 1'b1, in_de = 1'b0;
  logic [9:0]  in_r = '0, in_g = '0, in_b = '0;
  logic [9:0]  px_x, px_y;
  logic        px_valid, frame_done, locked, err_hline, err_vframe;
  logic [31:0] frame_sum;
  logic [18:0] lit_count;

  vga_frame_monitor #(.H_ACTIVE(H), .V_ACTIVE(V), .SYNC_POL(1'b0), .LOCK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .px_x(px_x), .px_y(px_y), .px_valid(px_valid),
    .frame_done(frame_done), .frame_sum(frame_sum), .lit_count(lit_count), .locked(locked),
    .err_hline(err_hline), .err_vframe(err_vframe)
  );

  always #20 clk = ~clk;

  typedef struct { logic [9:0] x; logic [9:0] y; } pix_t;
  typedef struct { logic [31:0] sum; logic [18:0] lit; logic ev; int eh; logic lk; } frm_t;

  pix_t pq[$];
  frm_t fq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int mx = 0, my = 0;
  logic [31:0] crc_acc = 32'hFFFF_FFFF;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

`ifdef VGA_MON_CRC_EN
  function automatic logic [31:0] crc_word(input logic [31:0] c, input logic [29:0] d);
    logic [31:0] n;
    n = c;
    for (int i = 29; i >= 0; i--) begin
      if (n[31] ^ d[i]) n = {n[30:0], 1'b0} ^ 32'h04C1_1DB7;
      else              n = {n[30:0], 1'b0};
    end
    return n;
  endfunction
`endif

  task automatic cyc(input logic de, input logic [9:0] r, input logic [9:0] g, input logic [9:0] b,
                     input logic hs, input logic vs);
    @(posedge clk); #1;
    in_de = de; in_r = r; in_g = g; in_b = b; in_hsync = hs; in_vsync = vs;
  endtask

  // pattern 1: white pixel at (3,2); pattern 2: (1,1)=1/0/5 (not lit), (4,4)=2/3/4 (lit)
  task automatic colour(input int pat, input int x, input int l,
                        output logic [9:0] r, output logic [9:0] g, output logic [9:0] b);
    r = '0; g = '0; b = '0;
    if (pat == 1 && x == 3 && l == 2) begin r = 10'd1023; g = 10'd1023; b = 10'd1023; end
    if (pat == 2 && x == 1 && l == 1) begin r = 10'd1; b = 10'd5; end
    if (pat == 2 && x == 4 && l == 4) begin r = 10'd2; g = 10'd3; b = 10'd4; end
  endtask

  task automatic pixels(input int n, input int start, input int pat, input int l);
    logic [9:0] r, g, b;
    for (int x = start; x < start + n; x++) begin
      colour(pat, x, l, r, g, b);
      pq.push_back('{x: 10'(mx), y: 10'(my)});
`ifdef VGA_MON_CRC_EN
      crc_acc = crc_word(crc_acc, {r, g, b});
`endif
      cyc(1'b1, r, g, b, 1'b1, 1'b1);
      mx++;
    end
  endtask

  task automatic blank_line();
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b1);
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b1);
    my++;
    mx = 0;
  endtask

  task automatic send_vsync(input bit push, input frm_t f);
    if (push) fq.push_back(f);
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b1);
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b1);
    mx = 0; my = 0;
    crc_acc = 32'hFFFF_FFFF;
  endtask

  // hand-computed sum/lit/error/lock expectations are passed in per frame
  task automatic send_frame(input int pat, input int nlines, input int bad_line, input int bad_len,
                            input logic [31:0] sum, input int lit, input bit ev, input int eh, input bit lk);
    frm_t f;
    for (int l = 0; l < nlines; l++) begin
      pixels((l == bad_line) ? bad_len : H, 0, pat, l);
      blank_line();
    end
    f.sum = sum;
`ifdef VGA_MON_CRC_EN
    f.sum = crc_acc;
`endif
    f.lit = 19'(lit); f.ev = ev; f.eh = eh; f.lk = lk;
    send_vsync(1'b1, f);
  endtask

  task automatic check_outputs_zero(input string nm);
    check({nm, "_ctl"}, 64'({px_x, px_y, px_valid, frame_done, locked, err_hline, err_vframe}), 64'd0);
    check({nm, "_sum"}, 64'({frame_sum, lit_count}), 64'd0);
  endtask

  // monitor: compare whatever the DUT presents against the queued expectations
  int eh_cnt = 0;
  bit lk_pend = 0;
  initial begin
    pix_t p;
    frm_t f;
    forever begin
      @(negedge clk);
      if (rst) begin
        eh_cnt = 0;
        lk_pend = 0;
      end else begin
        if (lk_pend) begin
          check("locked_after_err_hline", 64'(locked), 64'd0);
          lk_pend = 0;
        end
        if (err_hline) begin
          eh_cnt++;
          lk_pend = 1;
        end
        if (px_valid) begin
          if (pq.size() == 0) check("unexpected_px_valid", 64'(px_valid), 64'd0);
          else begin
            p = pq.pop_front();
            check("px_xy", 64'({px_x, px_y}), 64'({p.x, p.y}));
          end
        end
        if (err_vframe) check("err_vframe_with_frame_done", 64'(frame_done), 64'd1);
        if (frame_done) begin
          if (fq.size() == 0) check("unexpected_frame_done", 64'(frame_done), 64'd0);
          else begin
            f = fq.pop_front();
            check("frame_sum", 64'(frame_sum), 64'(f.sum));
            check("lit_count", 64'(lit_count), 64'(f.lit));
            check("err_vframe", 64'(err_vframe), 64'(f.ev));
            check("err_hline_count", 64'(eh_cnt), 64'(f.eh));
            check("locked", 64'(locked), 64'(f.lk));
          end
          eh_cnt = 0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    frm_t none;
    none = '{sum: '0, lit: '0, ev: 1'b0, eh: 0, lk: 1'b0};
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (3) cyc(1'b0, '0, '0, '0, 1'b1, 1'b1);
    send_vsync(1'b0, none);

    // black frames: lock after the second reported frame
    send_frame(0, V, -1, 0, 32'd0, 0, 1'b0, 0, 1'b0);
    send_frame(0, V, -1, 0, 32'd0, 0, 1'b0, 0, 1'b1);
    // signatures: single white pixel, then a mixed pattern
    send_frame(1, V, -1, 0, 32'd3069, 1, 1'b0, 0, 1'b1);
    send_frame(2, V, -1, 0, 32'd15, 1, 1'b0, 0, 1'b1);
    // short line drops lock; two good frames relock
    send_frame(0, V, 4, H - 1, 32'd0, 0, 1'b0, 1, 1'b0);
    send_frame(0, V, -1, 0, 32'd0, 0, 1'b0, 0, 1'b0);
    send_frame(0, V, -1, 0, 32'd0, 0, 1'b0, 0, 1'b1);
    // too few lines, long line, too many lines, then relock
    send_frame(0, V - 1, -1, 0, 32'd0, 0, 1'b1, 0, 1'b0);
    send_frame(0, V, 2, H + 1, 32'd0, 0, 1'b0, 1, 1'b0);
    send_frame(0, V + 1, -1, 0, 32'd0, 0, 1'b1, 0, 1'b0);
    send_frame(0, V, -1, 0, 32'd0, 0, 1'b0, 0, 1'b0);
    send_frame(0, V, -1, 0, 32'd0, 0, 1'b0, 0, 1'b1);

    // reset in the middle of line 2
    pixels(H, 0, 0, 0); blank_line();
    pixels(H, 0, 0, 1); blank_line();
    pixels(3, 0, 0, 2);
    @(posedge clk); #1;
    rst = 1'b1; in_de = 1'b0;
    @(posedge clk); #1;
    check_outputs_zero("mid_frame_reset");
    pq.delete();
    mx = 0; my = 0;
    rst = 1'b0;
    pixels(H - 3, 3, 0, 2); blank_line();
    for (int l = 3; l < V; l++) begin
      pixels(H, 0, 0, l);
      blank_line();
    end
    send_vsync(1'b0, none);
    send_frame(0, V, -1, 0, 32'd0, 0, 1'b0, 0, 1'b0);
    send_frame(1, V, -1, 0, 32'd3069, 1, 1'b0, 0, 1'b1);

    repeat (10) cyc(1'b0, '0, '0, '0, 1'b1, 1'b1);
    check("pixel_queue_drained", 64'(pq.size()), 64'd0);
    check("frame_queue_drained", 64'(fq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
